aes_key_expand: RTL and testbench



---
 rtl/aes_pkg.sv | 17 +
 rtl/aes_sbox.sv | 28 ++
 rtl/aes_key_expand.sv | 92 +++++++++
 tb/tb_aes_key_expand.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, RCON table, key-schedule FSM encoding and word types.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [0:127] block_t;
    typedef logic [0:31]  word_t;

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    // Entry 0 is unused so the table indexes directly by round number.
    localparam logic [7:0] RCON [0:AES_NR] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte per instance.
module aes_sbox (
    input  logic [7:0] b,
    output logic [7:0] sb
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign sb = SBOX[b];

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: expands one round key per clock into an 11-entry register store
// that the cipher reads by index with one-cycle latency.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int KW = 128
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    input  logic [0:KW-1] i_key,
    input  logic          i_key_valid,
    output logic          o_key_ready,
    input  logic [3:0]    i_rk_idx,
    output logic [0:KW-1] o_rk,
    output logic          o_keys_valid,
    output logic          o_busy
);

    state_t     state, state_nxt;
    logic [3:0] r;
    block_t     w, w_nxt;
    block_t     rk [0:NR];
    word_t      rot, sub, t, n0, n1, n2, n3;
    logic       accept;

    // RotWord of w3, then SubWord through four S-box lanes.
    assign rot = {w[104:127], w[96:103]};

    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (.b(rot[8*g +: 8]), .sb(sub[8*g +: 8]));
    end

    assign t     = sub ^ {RCON[r], 24'h0};
    assign n0    = w[0:31]  ^ t;
    assign n1    = w[32:63] ^ n0;
    assign n2    = w[64:95] ^ n1;
    assign n3    = w[96:127] ^ n2;
    assign w_nxt = {n0, n1, n2, n3};

    assign accept = i_key_valid && o_key_ready;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        o_key_ready  = 1'b0;
        o_keys_valid = 1'b0;
        o_busy       = 1'b0;
        case (state)
            IDLE: begin
                o_key_ready = 1'b1;
                if (i_key_valid) state_nxt = EXPAND;
            end
            EXPAND: begin
                o_busy = 1'b1;
                if (r == 4'(NR)) state_nxt = DONE;
            end
            DONE: begin
                o_key_ready  = 1'b1;
                o_keys_valid = 1'b1;
                if (i_key_valid) state_nxt = EXPAND;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Store is plain flops so reset can clear every entry.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r    <= '0;
            w    <= '0;
            o_rk <= '0;
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
        end else begin
            if (accept) begin
                rk[0] <= i_key;
                w     <= i_key;
                r     <= 4'd1;
            end else if (state == EXPAND) begin
                rk[r] <= w_nxt;
                w     <= w_nxt;
                r     <= r + 4'd1;
            end
            o_rk <= (i_rk_idx <= 4'(NR)) ? rk[i_rk_idx] : '0;
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 and all-zero key schedules.
module tb_aes_key_expand;

    localparam logic [0:127] FIPS_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] FIPS_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [0:127] FIPS_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [0:127] ZERO_RK1   = 128'h62636363626363636263636362636363;
    localparam logic [0:127] ZERO_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [0:127] ALT_KEY    = 128'h00112233445566778899aabbccddeeff;

    logic         i_clock = 1'b0;
    logic         i_reset_n;
    logic [0:127] i_key;
    logic         i_key_valid;
    logic         o_key_ready;
    logic [3:0]   i_rk_idx;
    logic [0:127] o_rk;
    logic         o_keys_valid;
    logic         o_busy;

    int checks = 0;
    int passes = 0;

    aes_key_expand dut (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_key        (i_key),
        .i_key_valid  (i_key_valid),
        .o_key_ready  (o_key_ready),
        .i_rk_idx     (i_rk_idx),
        .o_rk         (o_rk),
        .o_keys_valid (o_keys_valid),
        .o_busy       (o_busy)
    );

    always #5 i_clock = ~i_clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Present an index and return what o_rk shows one edge later.
    task automatic read_rk(input logic [3:0] idx, output logic [0:127] val);
        i_rk_idx = idx;
        @(posedge i_clock); #1;
        val = o_rk;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0; i_key = '0; i_key_valid = 1'b0; i_rk_idx = 4'd0;
        #12;
        checks++; if (o_key_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", o_key_ready); else passes++;
        checks++; if (o_keys_valid !== 1'b0) $display("FAIL reset_keys_valid: got %b want 0", o_keys_valid); else passes++;
        checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else passes++;
        checks++; if (o_rk !== 128'h0) $display("FAIL reset_rk: got %h want 0", o_rk); else passes++;
        i_reset_n = 1'b1;
        @(posedge i_clock); #1;
    endtask

    task automatic test_fips();
        logic [0:127] v;
        i_key = FIPS_KEY; i_key_valid = 1'b1;
        @(posedge i_clock); #1;
        i_key_valid = 1'b0;
        checks++; if (o_busy !== 1'b1) $display("FAIL fips_busy_T0: got %b want 1", o_busy); else passes++;
        checks++; if (o_key_ready !== 1'b0) $display("FAIL fips_ready_T0: got %b want 0", o_key_ready); else passes++;
        repeat (9) @(posedge i_clock);
        #1;
        checks++; if (o_keys_valid !== 1'b0) $display("FAIL fips_valid_T9: got %b want 0", o_keys_valid); else passes++;
        checks++; if (o_busy !== 1'b1) $display("FAIL fips_busy_T9: got %b want 1", o_busy); else passes++;
        @(posedge i_clock); #1;
        checks++; if (o_keys_valid !== 1'b1) $display("FAIL fips_valid_T10: got %b want 1", o_keys_valid); else passes++;
        checks++; if (o_busy !== 1'b0) $display("FAIL fips_busy_T10: got %b want 0", o_busy); else passes++;
        read_rk(4'd0, v);
        checks++; if (v !== FIPS_KEY) $display("FAIL fips_rk0: got %h want %h", v, FIPS_KEY); else passes++;
        read_rk(4'd1, v);
        checks++; if (v !== FIPS_RK1) $display("FAIL fips_rk1: got %h want %h", v, FIPS_RK1); else passes++;
        read_rk(4'd10, v);
        checks++; if (v !== FIPS_RK10) $display("FAIL fips_rk10: got %h want %h", v, FIPS_RK10); else passes++;
    endtask

    task automatic test_restart_zero();
        logic [0:127] v;
        i_key = '0; i_key_valid = 1'b1;
        @(posedge i_clock); #1;
        i_key_valid = 1'b0;
        checks++; if (o_keys_valid !== 1'b0) $display("FAIL restart_valid_drop: got %b want 0", o_keys_valid); else passes++;
        repeat (9) @(posedge i_clock);
        #1;
        checks++; if (o_keys_valid !== 1'b0) $display("FAIL restart_valid_T9: got %b want 0", o_keys_valid); else passes++;
        @(posedge i_clock); #1;
        checks++; if (o_keys_valid !== 1'b1) $display("FAIL restart_valid_T10: got %b want 1", o_keys_valid); else passes++;
        read_rk(4'd0, v);
        checks++; if (v !== 128'h0) $display("FAIL zero_rk0: got %h want 0", v); else passes++;
        read_rk(4'd1, v);
        checks++; if (v !== ZERO_RK1) $display("FAIL zero_rk1: got %h want %h", v, ZERO_RK1); else passes++;
        read_rk(4'd10, v);
        checks++; if (v !== ZERO_RK10) $display("FAIL zero_rk10: got %h want %h", v, ZERO_RK10); else passes++;
    endtask

    task automatic test_ignore_valid();
        logic [0:127] v;
        int bad_ready = 0;
        i_key = FIPS_KEY; i_key_valid = 1'b1;
        @(posedge i_clock); #1;
        i_key = ALT_KEY;
        for (int c = 0; c < 9; c++) begin
            if (o_key_ready !== 1'b0) bad_ready++;
            @(posedge i_clock); #1;
        end
        checks++; if (bad_ready != 0) $display("FAIL ignore_ready_low: got %0d cycles ready want 0", bad_ready); else passes++;
        @(posedge i_clock); #1;
        i_key_valid = 1'b0;
        checks++; if (o_keys_valid !== 1'b1) $display("FAIL ignore_valid_T10: got %b want 1", o_keys_valid); else passes++;
        read_rk(4'd0, v);
        checks++; if (v !== FIPS_KEY) $display("FAIL ignore_rk0: got %h want %h", v, FIPS_KEY); else passes++;
        read_rk(4'd10, v);
        checks++; if (v !== FIPS_RK10) $display("FAIL ignore_rk10: got %h want %h", v, FIPS_RK10); else passes++;
    endtask

    task automatic test_read_bounds();
        logic [0:127] v;
        read_rk(4'd11, v);
        checks++; if (v !== 128'h0) $display("FAIL read_idx11: got %h want 0", v); else passes++;
        read_rk(4'd15, v);
        checks++; if (v !== 128'h0) $display("FAIL read_idx15: got %h want 0", v); else passes++;
        i_rk_idx = 4'd10;
        @(posedge i_clock); #1;
        checks++; if (o_rk !== FIPS_RK10) $display("FAIL b2b_idx10: got %h want %h", o_rk, FIPS_RK10); else passes++;
        i_rk_idx = 4'd0;
        @(posedge i_clock); #1;
        checks++; if (o_rk !== FIPS_KEY) $display("FAIL b2b_idx0: got %h want %h", o_rk, FIPS_KEY); else passes++;
    endtask

    task automatic test_reset_mid_expand();
        logic [0:127] v;
        i_rk_idx = 4'd1;
        i_key = FIPS_KEY; i_key_valid = 1'b1;
        @(posedge i_clock); #1;
        i_key_valid = 1'b0;
        repeat (4) @(posedge i_clock);
        #1;
        i_reset_n = 1'b0;
        #1;
        checks++; if (o_key_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", o_key_ready); else passes++;
        checks++; if (o_keys_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", o_keys_valid); else passes++;
        checks++; if (o_busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", o_busy); else passes++;
        checks++; if (o_rk !== 128'h0) $display("FAIL midrst_rk: got %h want 0", o_rk); else passes++;
        #1;
        i_reset_n = 1'b1;
        read_rk(4'd3, v);
        checks++; if (v !== 128'h0) $display("FAIL midrst_idx3: got %h want 0", v); else passes++;
        read_rk(4'd0, v);
        checks++; if (v !== 128'h0) $display("FAIL midrst_idx0: got %h want 0", v); else passes++;
        checks++; if (o_busy !== 1'b0) $display("FAIL midrst_no_resume: got busy %b want 0", o_busy); else passes++;
        i_key = FIPS_KEY; i_key_valid = 1'b1;
        @(posedge i_clock); #1;
        i_key_valid = 1'b0;
        repeat (10) @(posedge i_clock);
        #1;
        checks++; if (o_keys_valid !== 1'b1) $display("FAIL midrst_rexp_valid: got %b want 1", o_keys_valid); else passes++;
        read_rk(4'd1, v);
        checks++; if (v !== FIPS_RK1) $display("FAIL midrst_rk1: got %h want %h", v, FIPS_RK1); else passes++;
        read_rk(4'd10, v);
        checks++; if (v !== FIPS_RK10) $display("FAIL midrst_rk10: got %h want %h", v, FIPS_RK10); else passes++;
    endtask

    initial begin
        test_reset();
        test_fips();
        test_restart_zero();
        test_ignore_valid();
        test_read_bounds();
        test_reset_mid_expand();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
